// File: rtl/maze_solve_adapt_pkg.sv
// Shared types for the adaptive wall-follower maze solver: directions, turn kinds,
// FSM states and the mode encodings used by cmd_proc.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_W = 2'd1,
    DIR_S = 2'd2,
    DIR_E = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    TURN_LEFT  = 2'd0,
    TURN_RIGHT = 2'd1,
    TURN_UTURN = 2'd2
  } turn_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FRWD = 3'd1,
    ST_HDNG = 3'd2,
    ST_ROT  = 3'd3,
    ST_KICK = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [1:0] MODE_RIGHT      = 2'b00;
  localparam logic [1:0] MODE_LEFT       = 2'b01;
  localparam logic [1:0] MODE_ALT        = 2'b10;
  localparam logic [1:0] MODE_LEFT_ALIAS = 2'b11;

  // Every mode except right-hand starts a run with left affinity.
  function automatic logic aff_lft_from_mode(input logic [1:0] mode);
    return (mode == MODE_LEFT) || (mode == MODE_ALT) || (mode == MODE_LEFT_ALIAS);
  endfunction

endpackage

// File: rtl/maze_solve_adapt_hdng_dec.sv
// Combinational turn decision: preferred side if open, else the other side, else U-turn.
module hdng_dec
  import maze_pkg::*;
(
  input  dir_t  i_dir,
  input  logic  i_aff_lft,
  input  logic  i_lft_opn,
  input  logic  i_rght_opn,
  output dir_t  o_nxt_dir,
  output turn_t o_turn
);

  turn_t w_turn;

  // Pick the turn from affinity and the openings seen at this stop.
  always_comb begin
    w_turn = TURN_UTURN;
    if (i_aff_lft) begin
      if (i_lft_opn)       w_turn = TURN_LEFT;
      else if (i_rght_opn) w_turn = TURN_RIGHT;
      else                 w_turn = TURN_UTURN;
    end else begin
      if (i_rght_opn)      w_turn = TURN_RIGHT;
      else if (i_lft_opn)  w_turn = TURN_LEFT;
      else                 w_turn = TURN_UTURN;
    end
  end

  // Left is +1, right is -1 and a U-turn is +2, all modulo 4.
  always_comb begin
    o_nxt_dir = i_dir;
    case (w_turn)
      TURN_LEFT:  o_nxt_dir = dir_t'(i_dir + 2'd1);
      TURN_RIGHT: o_nxt_dir = dir_t'(i_dir - 2'd1);
      TURN_UTURN: o_nxt_dir = dir_t'(i_dir + 2'd2);
      default:    o_nxt_dir = i_dir;
    endcase
  end

  assign o_turn = w_turn;

endmodule

// File: rtl/maze_solve_adapt.sv
// Adaptive wall-follower: picks a turn at every stop, drives rotate/move kicks,
// flips affinity on runaway turn sums and ends the run on solution or move limit.
module maze_solve_adapt
  import maze_pkg::*;
#(
  parameter int                HDNG_W     = 12,
  parameter logic [HDNG_W-1:0] NORTH_HDNG = 12'h000,
  parameter logic [HDNG_W-1:0] WEST_HDNG  = 12'h3FF,
  parameter logic [HDNG_W-1:0] SOUTH_HDNG = 12'h7FF,
  parameter logic [HDNG_W-1:0] EAST_HDNG  = 12'hC00,
  parameter int                CNT_W      = 10,
  parameter int                MAX_MOVES  = 1023,
  parameter int                TS_W       = 6,
  parameter int                LOOP_LIM   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_go,
  input  logic [1:0]               i_mode,
  input  logic                     i_abort,
  input  logic                     i_lft_opn,
  input  logic                     i_rght_opn,
  input  logic                     i_mv_cmplt,
  input  logic                     i_sol_cmplt,
  output logic                     o_strt_mv,
  output logic                     o_strt_hdng,
  output logic [HDNG_W-1:0]        o_dsrd_hdng,
  output logic                     o_stp_lft,
  output logic                     o_stp_rght,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_timeout,
  output logic [CNT_W-1:0]         o_mv_cnt,
  output logic signed [TS_W-1:0]   o_turn_sum
);

  localparam logic signed [TS_W+1:0] TS_MAX = (TS_W+2)'(2**(TS_W-1) - 1);
  localparam logic signed [TS_W+1:0] TS_MIN = (TS_W+2)'(-(2**(TS_W-1)));

  state_t                  r_state;
  dir_t                    r_dir;
  logic [HDNG_W-1:0]       r_hdng;
  logic                    r_aff_lft;
  logic                    r_strt_mv;
  logic                    r_strt_hdng;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_timeout;
  logic [CNT_W-1:0]        r_mv_cnt;
  logic signed [TS_W-1:0]  r_turn_sum;

  dir_t                    w_nxt_dir;
  turn_t                   w_turn;
  logic signed [TS_W+1:0]  w_ts_delta;
  logic signed [TS_W+1:0]  w_ts_wide;
  logic signed [TS_W+1:0]  w_ts_clamp;
  logic signed [TS_W+1:0]  w_ts_abs;
  logic                    w_alt;
  logic                    w_loop;
  logic signed [TS_W-1:0]  w_ts_nxt;
  logic                    w_aff_nxt;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_to_hit;

  function automatic logic [HDNG_W-1:0] hdng_of(input dir_t d);
    case (d)
      DIR_N:   return NORTH_HDNG;
      DIR_W:   return WEST_HDNG;
      DIR_S:   return SOUTH_HDNG;
      DIR_E:   return EAST_HDNG;
      default: return NORTH_HDNG;
    endcase
  endfunction

  hdng_dec u_hdng_dec (
    .i_dir      (r_dir),
    .i_aff_lft  (r_aff_lft),
    .i_lft_opn  (i_lft_opn),
    .i_rght_opn (i_rght_opn),
    .o_nxt_dir  (w_nxt_dir),
    .o_turn     (w_turn)
  );

  // Turn-sum update with saturation, plus the loop rule that may flip affinity.
  always_comb begin
    w_ts_delta = (TS_W+2)'(0);
    case (w_turn)
      TURN_LEFT:  w_ts_delta = (TS_W+2)'(1);
      TURN_RIGHT: w_ts_delta = (TS_W+2)'(-1);
      TURN_UTURN: w_ts_delta = r_aff_lft ? (TS_W+2)'(2) : (TS_W+2)'(-2);
      default:    w_ts_delta = (TS_W+2)'(0);
    endcase
    w_ts_wide = {{2{r_turn_sum[TS_W-1]}}, r_turn_sum} + w_ts_delta;
    if (w_ts_wide > TS_MAX)      w_ts_clamp = TS_MAX;
    else if (w_ts_wide < TS_MIN) w_ts_clamp = TS_MIN;
    else                         w_ts_clamp = w_ts_wide;
    if (w_ts_clamp < (TS_W+2)'(0)) w_ts_abs = -w_ts_clamp;
    else                           w_ts_abs = w_ts_clamp;
    w_alt  = (i_mode == MODE_ALT);
    w_loop = !w_alt && (LOOP_LIM != 0) && (int'(w_ts_abs) >= LOOP_LIM);
    if (w_loop) w_ts_nxt = '0;
    else        w_ts_nxt = w_ts_clamp[TS_W-1:0];
    if (w_alt || w_loop) w_aff_nxt = ~r_aff_lft;
    else                 w_aff_nxt = r_aff_lft;
  end

  // Saturating move count and the move-limit check against the incremented value.
  always_comb begin
    if (r_mv_cnt == {CNT_W{1'b1}}) w_cnt_inc = r_mv_cnt;
    else                           w_cnt_inc = r_mv_cnt + CNT_W'(1);
    w_to_hit = (MAX_MOVES != 0) && (w_cnt_inc == CNT_W'(MAX_MOVES));
  end

  // Run sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_N;
      r_hdng      <= NORTH_HDNG;
      r_aff_lft   <= 1'b0;
      r_strt_mv   <= 1'b0;
      r_strt_hdng <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_mv_cnt    <= '0;
      r_turn_sum  <= '0;
    end else begin
      r_strt_mv   <= 1'b0;
      r_strt_hdng <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_go) begin
            r_dir      <= DIR_N;
            r_hdng     <= NORTH_HDNG;
            r_mv_cnt   <= '0;
            r_turn_sum <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_aff_lft  <= aff_lft_from_mode(i_mode);
            r_strt_mv  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_FRWD;
          end
        end
        ST_FRWD: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (i_mv_cmplt) begin
            if (i_sol_cmplt) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_mv_cnt <= w_cnt_inc;
              if (w_to_hit) begin
                r_timeout <= 1'b1;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= ST_DONE;
              end else begin
                r_dir       <= w_nxt_dir;
                r_hdng      <= hdng_of(w_nxt_dir);
                r_turn_sum  <= w_ts_nxt;
                r_aff_lft   <= w_aff_nxt;
                r_strt_hdng <= 1'b1;
                r_state     <= ST_HDNG;
              end
            end
          end
        end
        ST_HDNG: r_state <= ST_ROT;
        ST_ROT: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (i_mv_cmplt) begin
            r_strt_mv <= 1'b1;
            r_state   <= ST_KICK;
          end
        end
        ST_KICK: r_state <= ST_FRWD;
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_strt_mv   = r_strt_mv;
  assign o_strt_hdng = r_strt_hdng;
  assign o_dsrd_hdng = r_hdng;
  assign o_stp_lft   = r_aff_lft;
  assign o_stp_rght  = ~r_aff_lft;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_timeout   = r_timeout;
  assign o_mv_cnt    = r_mv_cnt;
  assign o_turn_sum  = r_turn_sum;

endmodule

// File: tb/tb_maze_solve_adapt.sv
// Scoreboard bench for maze_solve_adapt: two instances (loop limit 4, move limit 3) share stimulus;
// decisions are queued when a stop is driven and checked when the selected instance kicks a rotate.
module tb_maze_solve_adapt;
  import maze_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go = 1'b0, abort = 1'b0, lft_opn = 1'b0, rght_opn = 1'b0;
  logic mv_cmplt = 1'b0, sol_cmplt = 1'b0;
  logic [1:0] mode = 2'b00;
  logic sel = 1'b0;

  logic a_strt_mv, a_strt_hdng, a_stp_lft, a_stp_rght, a_busy, a_done, a_timeout;
  logic [11:0] a_dsrd_hdng;
  logic [9:0] a_mv_cnt;
  logic signed [5:0] a_turn_sum;
  logic b_strt_mv, b_strt_hdng, b_stp_lft, b_stp_rght, b_busy, b_done, b_timeout;
  logic [11:0] b_dsrd_hdng;
  logic [9:0] b_mv_cnt;
  logic signed [5:0] b_turn_sum;

  logic m_strt_mv, m_strt_hdng, m_stp_lft, m_stp_rght, m_busy, m_done, m_timeout;
  logic [11:0] m_dsrd_hdng;
  logic [9:0] m_mv_cnt;
  logic signed [5:0] m_turn_sum;

  typedef struct {int hdng; int ts; int lft;} exp_t;
  exp_t sb_q[$];
  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  maze_solve_adapt #(.LOOP_LIM(4)) u_a (
    .clk(clk), .rst_n(rst_n), .i_go(go), .i_mode(mode), .i_abort(abort),
    .i_lft_opn(lft_opn), .i_rght_opn(rght_opn), .i_mv_cmplt(mv_cmplt), .i_sol_cmplt(sol_cmplt),
    .o_strt_mv(a_strt_mv), .o_strt_hdng(a_strt_hdng), .o_dsrd_hdng(a_dsrd_hdng),
    .o_stp_lft(a_stp_lft), .o_stp_rght(a_stp_rght), .o_busy(a_busy), .o_done(a_done),
    .o_timeout(a_timeout), .o_mv_cnt(a_mv_cnt), .o_turn_sum(a_turn_sum)
  );

  maze_solve_adapt #(.MAX_MOVES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .i_go(go), .i_mode(mode), .i_abort(abort),
    .i_lft_opn(lft_opn), .i_rght_opn(rght_opn), .i_mv_cmplt(mv_cmplt), .i_sol_cmplt(sol_cmplt),
    .o_strt_mv(b_strt_mv), .o_strt_hdng(b_strt_hdng), .o_dsrd_hdng(b_dsrd_hdng),
    .o_stp_lft(b_stp_lft), .o_stp_rght(b_stp_rght), .o_busy(b_busy), .o_done(b_done),
    .o_timeout(b_timeout), .o_mv_cnt(b_mv_cnt), .o_turn_sum(b_turn_sum)
  );

  always_comb begin
    if (sel) begin
      m_strt_mv = b_strt_mv; m_strt_hdng = b_strt_hdng; m_dsrd_hdng = b_dsrd_hdng;
      m_stp_lft = b_stp_lft; m_stp_rght = b_stp_rght; m_busy = b_busy; m_done = b_done;
      m_timeout = b_timeout; m_mv_cnt = b_mv_cnt; m_turn_sum = b_turn_sum;
    end else begin
      m_strt_mv = a_strt_mv; m_strt_hdng = a_strt_hdng; m_dsrd_hdng = a_dsrd_hdng;
      m_stp_lft = a_stp_lft; m_stp_rght = a_stp_rght; m_busy = a_busy; m_done = a_done;
      m_timeout = a_timeout; m_mv_cnt = a_mv_cnt; m_turn_sum = a_turn_sum;
    end
  end

  task automatic check_value(input string tag, input int act, input int exp);
    chk_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Every rotate kick of the watched instance must match the oldest queued decision.
  always @(negedge clk) begin
    if (rst_n && m_strt_hdng) begin
      if (sb_q.size() == 0) begin
        check_value("sb_unexpected_hdng", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_value("sb_hdng", int'(m_dsrd_hdng), e.hdng);
        check_value("sb_turn_sum", int'(m_turn_sum), e.ts);
        check_value("sb_stp_lft", int'(m_stp_lft), e.lft);
        check_value("sb_stp_rght", int'(m_stp_rght), 1 - e.lft);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [1:0] md, input int exp_lft);
    mode = md;
    go = 1'b1;
    tick();
    go = 1'b0;
    check_value("go_strt_mv", int'(m_strt_mv), 1);
    check_value("go_busy", int'(m_busy), 1);
    check_value("go_hdng_north", int'(m_dsrd_hdng), 'h000);
    check_value("go_stp_lft", int'(m_stp_lft), exp_lft);
    check_value("go_mv_cnt", int'(m_mv_cnt), 0);
    tick();
    check_value("go_strt_mv_lo", int'(m_strt_mv), 0);
  endtask

  task automatic do_stop(input logic l, input logic r, input int eh, input int ets,
                         input int elft, input logic rot);
    exp_t e;
    e.hdng = eh; e.ts = ets; e.lft = elft;
    sb_q.push_back(e);
    lft_opn = l; rght_opn = r; mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0; lft_opn = 1'b0; rght_opn = 1'b0;
    check_value("strt_hdng_hi", int'(m_strt_hdng), 1);
    tick();
    check_value("strt_hdng_lo", int'(m_strt_hdng), 0);
    if (rot) begin
      mv_cmplt = 1'b1;
      tick();
      mv_cmplt = 1'b0;
      check_value("kick_strt_mv", int'(m_strt_mv), 1);
      tick();
      check_value("kick_strt_mv_lo", int'(m_strt_mv), 0);
    end
  endtask

  initial begin
    repeat (2) tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_value("rst_hdng", int'(m_dsrd_hdng), 'h000);
      check_value("rst_stp_rght", int'(m_stp_rght), 1);
      check_value("rst_stp_lft", int'(m_stp_lft), 0);
      check_value("rst_flags", int'({m_busy, m_done, m_timeout, m_strt_mv, m_strt_hdng}), 0);
      check_value("rst_cnt_ts", int'(m_mv_cnt) + int'(m_turn_sum), 0);
    end
    rst_n = 1'b1;
    tick();

    // Left-hand run: one left turn, then abort coincident with a move completion.
    sel = 1'b1;
    start_run(MODE_LEFT, 1);
    do_stop(1'b1, 1'b0, 'h3FF, 1, 1, 1'b1);
    check_value("lh_mv_cnt", int'(m_mv_cnt), 1);
    abort = 1'b1; mv_cmplt = 1'b1; lft_opn = 1'b1;
    tick();
    abort = 1'b0; mv_cmplt = 1'b0; lft_opn = 1'b0;
    check_value("abort_busy", int'(m_busy), 0);
    check_value("abort_hdng_kept", int'(m_dsrd_hdng), 'h3FF);
    check_value("abort_mv_cnt", int'(m_mv_cnt), 1);
    check_value("abort_no_hdng", int'(m_strt_hdng), 0);
    tick();
    check_value("abort_no_hdng2", int'(m_strt_hdng), 0);

    // Right-hand dead ends, then the third move hits the limit of 3.
    start_run(MODE_RIGHT, 0);
    do_stop(1'b0, 1'b0, 'h7FF, -2, 0, 1'b1);
    do_stop(1'b0, 1'b0, 'h000, -4, 0, 1'b1);
    lft_opn = 1'b1; rght_opn = 1'b1; mv_cmplt = 1'b1;
    tick();
    lft_opn = 1'b0; rght_opn = 1'b0; mv_cmplt = 1'b0;
    check_value("to_done", int'(m_done), 1);
    check_value("to_timeout", int'(m_timeout), 1);
    check_value("to_mv_cnt", int'(m_mv_cnt), 3);
    check_value("to_busy", int'(m_busy), 0);
    tick();
    check_value("to_done_held", int'(m_done), 1);
    go = 1'b1;
    tick();
    go = 1'b0;
    check_value("restart_done_clr", int'(m_done), 0);
    check_value("restart_to_clr", int'(m_timeout), 0);
    check_value("restart_cnt_clr", int'(m_mv_cnt), 0);
    tick();
    mv_cmplt = 1'b1; sol_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    check_value("sol_done", int'(m_done), 1);
    check_value("sol_timeout", int'(m_timeout), 0);
    check_value("sol_busy", int'(m_busy), 0);

    // Loop detection on the LOOP_LIM=4 instance: four rights flip affinity to left.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sel = 1'b0;
    tick();
    start_run(MODE_RIGHT, 0);
    do_stop(1'b0, 1'b1, 'hC00, -1, 0, 1'b1);
    do_stop(1'b0, 1'b1, 'h7FF, -2, 0, 1'b1);
    do_stop(1'b0, 1'b1, 'h3FF, -3, 0, 1'b1);
    do_stop(1'b0, 1'b1, 'h000, 0, 1, 1'b1);
    do_stop(1'b1, 1'b1, 'h3FF, 1, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_value("rst_rot_hdng", int'(m_dsrd_hdng), 'h000);
    check_value("rst_rot_busy", int'(m_busy), 0);
    check_value("rst_rot_stp_lft", int'(m_stp_lft), 0);
    check_value("rst_rot_ts", int'(m_turn_sum), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Alternate mode with both openings at every stop: W, N, W.
    start_run(MODE_ALT, 1);
    do_stop(1'b1, 1'b1, 'h3FF, 1, 0, 1'b1);
    do_stop(1'b1, 1'b1, 'h000, 0, 1, 1'b1);
    do_stop(1'b1, 1'b1, 'h3FF, 1, 0, 1'b1);
    check_value("alt_mv_cnt", int'(m_mv_cnt), 3);

    tick();
    check_value("sb_leftover", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
